// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
//
// Write-back buffer in front of the register file's single write port.
// Results from the ALU and the load unit are accepted over valid/ready
// handshakes, held in an in-order circular FIFO of {addr, data}, and retired
// one per cycle onto the regfile write interface. Two lookup ports let decode
// forward values that are still pending in the buffer.
//
// Optional feature (macro WBQ_BYPASS_EN):
//   When the queue is empty, drain_hold is low and a non-x0 result is accepted,
//   that result is written to the regfile in the same cycle instead of being
//   enqueued. If both producers are accepted, the load result bypasses and the
//   ALU result is enqueued. Lookups also see the bypassed result that cycle.
//   With the macro undefined there is no bypass and the minimum latency is one
//   cycle.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   alu_valid/ready/rd/data  ALU result handshake
//   mem_valid/ready/rd/data  load result handshake (wins the last free slot)
//   drain_hold               inhibits retirement this cycle
//   wr_en/wr_addr/wr_data    regfile write port (head entry, combinational)
//   lk_addr1/2               forwarding lookup addresses
//   lk_hit1/2, lk_data1/2    hit flag and youngest matching data
//   count                    number of occupied entries
// -----------------------------------------------------------------------------
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       drain_hold,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    input  logic [ADDR_W-1:0]          lk_addr1,
    input  logic [ADDR_W-1:0]          lk_addr2,
    output logic                       lk_hit1,
    output logic                       lk_hit2,
    output logic [DATA_W-1:0]          lk_data1,
    output logic [DATA_W-1:0]          lk_data2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Storage and pointers
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // Per-cycle control
    logic [CNT_W-1:0]  free_s;
    logic              mem_push_s;
    logic              alu_push_s;
    logic              mem_byp_s;
    logic              alu_byp_s;
    logic              mem_enq_s;
    logic              alu_enq_s;
    logic              pop_s;
    logic [PTR_W-1:0]  alu_slot_s;
    logic [PTR_W-1:0]  lk_idx_s;

    assign count = count_q;

    // Readiness from the occupancy at the start of the cycle; a same-cycle pop
    // earns no credit, and the load unit keeps the last free slot.
    always_comb begin
        free_s = CNT_W'(DEPTH) - count_q;
        if (rst) begin
            mem_ready = (free_s >= CNT_W'(1));
            alu_ready = (free_s >= CNT_W'(2)) ||
                        ((free_s == CNT_W'(1)) && !mem_valid);
        end else begin
            mem_ready = 1'b0;
            alu_ready = 1'b0;
        end
    end

    // Accepted transfers to x0 complete the handshake but never occupy a slot.
    assign mem_push_s = mem_valid && mem_ready && (mem_rd != {ADDR_W{1'b0}});
    assign alu_push_s = alu_valid && alu_ready && (alu_rd != {ADDR_W{1'b0}});
    assign pop_s      = rst && (count_q != {CNT_W{1'b0}}) && !drain_hold;

`ifdef WBQ_BYPASS_EN
    // Zero-latency path: only legal when nothing older is waiting to retire.
    always_comb begin
        if (rst && (count_q == {CNT_W{1'b0}}) && !drain_hold) begin
            mem_byp_s = mem_push_s;
            alu_byp_s = alu_push_s && !mem_push_s;
        end else begin
            mem_byp_s = 1'b0;
            alu_byp_s = 1'b0;
        end
    end
`else
    assign mem_byp_s = 1'b0;
    assign alu_byp_s = 1'b0;
`endif

    assign mem_enq_s = mem_push_s && !mem_byp_s;
    assign alu_enq_s = alu_push_s && !alu_byp_s;

    // Regfile write port: bypassed result if any, otherwise the head entry.
    always_comb begin
        wr_en = pop_s || mem_byp_s || alu_byp_s;
        if (mem_byp_s) begin
            wr_addr = mem_rd;
            wr_data = mem_data;
        end else if (alu_byp_s) begin
            wr_addr = alu_rd;
            wr_data = alu_data;
        end else if (pop_s) begin
            wr_addr = addr_q[head_q];
            wr_data = data_q[head_q];
        end else begin
            wr_addr = {ADDR_W{1'b0}};
            wr_data = {DATA_W{1'b0}};
        end
    end

    // Next-state for the FIFO: retire at head, enqueue mem then alu at tail.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;

        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        // mem is the older of two simultaneous results, so it takes tail.
        if (mem_enq_s) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = mem_rd;
            data_d[tail_q]  = mem_data;
        end else begin
            valid_d[tail_q] = valid_d[tail_q];
        end

        alu_slot_s = tail_q + PTR_W'(mem_enq_s);
        if (alu_enq_s) begin
            valid_d[alu_slot_s] = 1'b1;
            addr_d[alu_slot_s]  = alu_rd;
            data_d[alu_slot_s]  = alu_data;
        end else begin
            valid_d[alu_slot_s] = valid_d[alu_slot_s];
        end

        tail_d  = tail_q + PTR_W'(mem_enq_s) + PTR_W'(alu_enq_s);
        count_d = count_q + CNT_W'(mem_enq_s) + CNT_W'(alu_enq_s) - CNT_W'(pop_s);
    end

    // Forwarding lookups: scan oldest to youngest so the youngest match wins.
    // Entries written this cycle are not yet in valid_q and so stay invisible.
    always_comb begin
        lk_hit1  = 1'b0;
        lk_hit2  = 1'b0;
        lk_data1 = {DATA_W{1'b0}};
        lk_data2 = {DATA_W{1'b0}};
        lk_idx_s = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx_s = head_q + PTR_W'(i);
            if (valid_q[lk_idx_s] && (addr_q[lk_idx_s] == lk_addr1)) begin
                lk_hit1  = 1'b1;
                lk_data1 = data_q[lk_idx_s];
            end else begin
                lk_hit1 = lk_hit1;
            end
            if (valid_q[lk_idx_s] && (addr_q[lk_idx_s] == lk_addr2)) begin
                lk_hit2  = 1'b1;
                lk_data2 = data_q[lk_idx_s];
            end else begin
                lk_hit2 = lk_hit2;
            end
        end
        // A bypassed result only exists when the queue is empty, so it is the
        // youngest (and only) candidate.
        if (mem_byp_s && (mem_rd == lk_addr1)) begin
            lk_hit1  = 1'b1;
            lk_data1 = mem_data;
        end else if (alu_byp_s && (alu_rd == lk_addr1)) begin
            lk_hit1  = 1'b1;
            lk_data1 = alu_data;
        end else begin
            lk_hit1 = lk_hit1;
        end
        if (mem_byp_s && (mem_rd == lk_addr2)) begin
            lk_hit2  = 1'b1;
            lk_data2 = mem_data;
        end else if (alu_byp_s && (alu_rd == lk_addr2)) begin
            lk_hit2  = 1'b1;
            lk_data2 = alu_data;
        end else begin
            lk_hit2 = lk_hit2;
        end
        // x0 never forwards, and nothing forwards while in reset.
        if (!rst || (lk_addr1 == {ADDR_W{1'b0}})) begin
            lk_hit1  = 1'b0;
            lk_data1 = {DATA_W{1'b0}};
        end else begin
            lk_hit1 = lk_hit1;
        end
        if (!rst || (lk_addr2 == {ADDR_W{1'b0}})) begin
            lk_hit2  = 1'b0;
            lk_data2 = {DATA_W{1'b0}};
        end else begin
            lk_hit2 = lk_hit2;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            valid_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {ADDR_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
